// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with single-block refill over a req/ack port.
// Latency: hit answers combinationally in the same cycle; a miss stalls 3 + N cycles (N = req-to-ack cycles).
// Backpressure: cpu_stall_o holds the PC while not served; the memory side may delay mem_ack_i indefinitely.
module icache_ctrl #(
    parameter int LINES  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [31:0]       cpu_instr_o,
    output logic              cpu_stall_o,
    input  logic              invalidate_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - 5 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        FILL
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [255:0]        data_q [LINES];

    logic [2:0]          cpu_word;
    logic [INDEX_W-1:0]  cpu_index;
    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  miss_index;
    logic [TAG_W-1:0]    miss_tag;
    logic                hit;
    logic                fill_we;
    logic                unused_addr_bits;

    assign cpu_word   = cpu_addr_i[4:2];
    assign cpu_index  = cpu_addr_i[5 +: INDEX_W];
    assign cpu_tag    = cpu_addr_i[ADDR_W-1:5+INDEX_W];
    assign miss_index = miss_addr_q[5 +: INDEX_W];
    assign miss_tag   = miss_addr_q[ADDR_W-1:5+INDEX_W];

    // Byte-offset bits never select anything in a word-wide fetch path.
    assign unused_addr_bits = ^{cpu_addr_i[1:0], miss_addr_q[4:0]};

    // Lookup: an invalidate in the same cycle forces a miss so the fetch refills after the clear.
    always_comb begin
        hit = cpu_req_i & valid_q[cpu_index] & (tag_q[cpu_index] == cpu_tag)
            & (state_q == IDLE) & ~invalidate_i;
        cpu_instr_o = hit ? data_q[cpu_index][{cpu_word, 5'b0} +: 32] : 32'h0;
        cpu_stall_o = (state_q != IDLE) | (cpu_req_i & ~hit);
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    // Next-state and refill control; the refill always targets the latched miss address.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (invalidate_i) begin
                    valid_d = '0;
                end
                if (cpu_req_i & ~hit) begin
                    state_d     = MISS;
                    miss_addr_d = cpu_addr_i;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {cpu_addr_i[ADDR_W-1:5], 5'b0};
                end
            end
            MISS: begin
                if (mem_ack_i) begin
                    fill_we             = 1'b1;
                    valid_d[miss_index] = 1'b1;
                    mem_req_d           = 1'b0;
                    state_d             = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state; reset abandons any refill in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Line write on refill ack; a conflicting tag simply overwrites the line.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[miss_index]  <= miss_tag;
            data_q[miss_index] <= mem_data_i;
        end
    end

endmodule
